// File: rtl/niosii_ms2hw_pio_sequencer.sv
// niosii_ms2hw_pio_sequencer: Avalon-MM PIO that plays software-loaded step patterns on out_port (optional irq via PIO_SEQ_IRQ_EN).
module niosii_ms2hw_pio_sequencer #(
  parameter int DATA_W   = 4,
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] buf_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [PERIOD_W-1:0] timer_q, timer_d, period_q, period_d, reload;
  logic loop_q, loop_d, ovf_q, ovf_d, done_q, done_d;
  logic wr, ctrl_wr, stat_wr, full, push_ok, last, unused_wdata;
  assign wr = chipselect & ~write_n;
  assign ctrl_wr = wr & (address == 3'd1);
  assign stat_wr = wr & (address == 3'd4);
  assign full = count_q == CNT_W'(DEPTH);
  assign push_ok = wr && address == 3'd3 && state_q == IDLE && !full;
  assign reload = period_q == '0 ? '0 : period_q - 1'b1;
  assign last = rd_idx_q == IDX_W'(count_q - 1'b1);
  assign unused_wdata = ^writedata;
  assign out_port = out_q;
`ifdef PIO_SEQ_IRQ_EN
  logic irq_en_q, irq_q;
  // IRQ_EN is a plain CTRL bit; irq follows DONE & IRQ_EN one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= writedata[3];
      irq_q <= done_q & irq_en_q;
    end
  end
  assign irq = irq_q;
`else
  logic irq_en_q;
  assign irq_en_q = 1'b0;
  assign irq = 1'b0;
`endif
  // Pattern storage has no reset; only the fill count is cleared
  always_ff @(posedge clk) begin
    if (push_ok) buf_q[count_q[IDX_W-1:0]] <= writedata[DATA_W-1:0];
  end
  // Register writes, playback stepping and flag updates
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    count_d  = count_q;
    rd_idx_d = rd_idx_q;
    timer_d  = timer_q;
    period_d = (wr && address == 3'd2) ? writedata[PERIOD_W-1:0] : period_q;
    loop_d   = ctrl_wr ? writedata[1] : loop_q;
    ovf_d    = ovf_q & ~(stat_wr & writedata[3]);
    done_d   = done_q & ~(stat_wr & writedata[4]);
    if (wr && address == 3'd3 && !push_ok) ovf_d = 1'b1;
    if (push_ok) count_d = count_q + 1'b1;
    if (state_q == IDLE) begin
      if (wr && address == 3'd0) out_d = writedata[DATA_W-1:0];
      if (wr && address == 3'd5) count_d = '0;
      if (ctrl_wr && writedata[0] && !writedata[2] && count_q != '0) begin
        state_d  = RUN;
        out_d    = buf_q[0];
        rd_idx_d = '0;
        timer_d  = reload;
      end
    end else if (ctrl_wr && writedata[2]) begin
      state_d = IDLE;
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end else if (!last || loop_q) begin
      rd_idx_d = last ? '0 : rd_idx_q + 1'b1;
      out_d    = last ? buf_q[0] : buf_q[rd_idx_q + 1'b1];
      timer_d  = reload;
    end else begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  // State register with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      out_q    <= '0;
      count_q  <= '0;
      rd_idx_q <= '0;
      timer_q  <= '0;
      period_q <= '0;
      loop_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      loop_q   <= loop_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end
  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[DATA_W-1:0] = out_q;
      3'd1: readdata[3:0] = {irq_en_q, 1'b0, loop_q, 1'b0};
      3'd2: readdata[PERIOD_W-1:0] = period_q;
      3'd4: readdata[11:0] = {4'(count_q), 3'b000, done_q, ovf_q, full, count_q == '0, state_q == RUN};
      default: ;
    endcase
  end
endmodule

// File: tb/tb_niosii_ms2hw_pio_sequencer.sv
// tb_niosii_ms2hw_pio_sequencer: directed and random checks of the PIO sequencer against a step-level model.
module tb_niosii_ms2hw_pio_sequencer;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [2:0] address = 0;
  logic [31:0] writedata = 0;
  logic [31:0] readdata;
  logic [3:0] out_port;
  logic irq;
  int vectors = 0, errors = 0;
  bit chk_en = 0;
`ifdef PIO_SEQ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  niosii_ms2hw_pio_sequencer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: a step is identified by its buffer position and how many cycles it has been shown
  bit m_run, m_loop, m_ien, m_ovf, m_done, m_irq;
  logic [3:0] m_out;
  logic [3:0] m_buf [8];
  logic [23:0] m_per;
  int m_cnt, m_pos, m_held, m_curp;

  task automatic show(int pos);
    m_pos = pos;
    m_out = m_buf[pos];
    m_held = 1;
    m_curp = (m_per == 0) ? 1 : int'(m_per);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_loop = 0; m_ien = 0; m_ovf = 0; m_done = 0; m_irq = 0;
      m_out = 0; m_per = 0; m_cnt = 0; m_pos = 0; m_held = 0; m_curp = 1;
    end else begin
      bit w, was_run, irq_next;
      w = chipselect && !write_n;
      was_run = m_run;
      irq_next = IRQ_ON && m_done && m_ien;
      if (w && address == 4) begin
        if (writedata[3]) m_ovf = 0;
        if (writedata[4]) m_done = 0;
      end
      if (was_run) begin
        if (w && address == 1 && writedata[2]) m_run = 0;
        else if (m_held < m_curp) m_held++;
        else if (m_pos < m_cnt - 1) show(m_pos + 1);
        else if (m_loop) show(0);
        else begin m_run = 0; m_done = 1; end
      end else if (w && address == 1 && writedata[0] && !writedata[2] && m_cnt > 0) begin
        show(0);
        m_run = 1;
      end
      if (w) begin
        case (address)
          3'd0: if (!was_run) m_out = writedata[3:0];
          3'd1: begin m_loop = writedata[1]; m_ien = IRQ_ON && writedata[3]; end
          3'd2: m_per = writedata[23:0];
          3'd3: if (was_run || m_cnt == 8) m_ovf = 1; else begin m_buf[m_cnt] = writedata[3:0]; m_cnt++; end
          3'd5: if (!was_run) m_cnt = 0;
          default: ;
        endcase
      end
      m_irq = irq_next;
    end
  end

  function automatic logic [31:0] exp_rd(logic [2:0] a);
    case (a)
      3'd0: return {28'd0, m_out};
      3'd1: return {28'd0, m_ien, 1'b0, m_loop, 1'b0};
      3'd2: return {8'd0, m_per};
      3'd4: return (32'(m_cnt) << 8) | {27'd0, m_done, m_ovf, m_cnt == 8, m_cnt == 0, m_run};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_port", 32'(out_port), 32'(m_out));
      check("irq", 32'(irq), 32'(m_irq));
      check("readdata", readdata, exp_rd(address));
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 0; write_n = 1;
  endtask

  task automatic peek(logic [2:0] a, logic [31:0] e, string name);
    address = a; #1;
    check(name, readdata, e);
  endtask

  initial begin
    logic [3:0] seq [10];
    int r;
    logic [2:0] a;
    logic [31:0] d;
    seq = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd4, 4'd4, 4'd4, 4'd4};
    @(posedge clk); #1;
    chk_en = 1;
    tick(1);
    reset_n = 1;
    peek(0, 0, "rst_data"); peek(1, 0, "rst_ctrl"); peek(2, 0, "rst_period");
    tick(1);
    peek(4, 32'h002, "rst_status");
    check("rst_out", 32'(out_port), 0);
    wr(0, 32'hA);
    check("data_wr", 32'(out_port), 32'hA);
    wr(3, 1); wr(3, 2); wr(3, 4); wr(2, 3); wr(1, 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("seq%0d", i), 32'(out_port), 32'(seq[i]));
      tick(1);
    end
    peek(4, 32'h310, "done_status");
    wr(4, 32'h18); wr(5, 0); wr(3, 5); wr(3, 6); wr(2, 0); wr(1, 3);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("loop%0d", i), 32'(out_port), (i % 2 == 0) ? 32'd5 : 32'd6);
      tick(1);
    end
    wr(1, 4);
    check("stop_hold", 32'(out_port), 5);
    tick(2);
    check("stop_frozen", 32'(out_port), 5);
    peek(4, 32'h200, "stop_status");
    wr(5, 0);
    for (int i = 0; i < 9; i++) wr(3, 32'(i + 1));
    peek(4, 32'h80C, "full_status");
    wr(4, 8); wr(2, 5); wr(1, 1); wr(3, 7); wr(5, 0); wr(0, 32'hF);
    peek(4, 32'h80D, "run_ignore_status");
    check("run_ignore_out", 32'(out_port), 1);
    wr(1, 4); wr(4, 8); wr(5, 0); wr(1, 1);
    peek(4, 32'h002, "start_empty");
    wr(3, 3); wr(1, 5);
    peek(4, 32'h100, "stop_start");
    wr(2, 0); wr(1, 9);
    tick(2);
    check("irq_set", 32'(irq), 32'(IRQ_ON));
    wr(4, 32'h10);
    tick(1);
    check("irq_clr", 32'(irq), 0);
    wr(2, 100); wr(1, 1);
    tick(3);
    reset_n = 0; #1;
    check("rst_mid_out", 32'(out_port), 0);
    peek(4, 32'h002, "rst_mid_status");
    tick(1);
    reset_n = 1;
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(99));
      d = $urandom;
      if (r < 40) begin
        address = 3'($urandom_range(7));
        tick(1);
      end else begin
        a = 3'(r < 55 ? 3 : r < 65 ? 1 : r < 73 ? 2 : r < 81 ? 4 : r < 86 ? 5 : r < 93 ? 0 : int'($urandom_range(6, 7)));
        if (a == 1) d[2] = ($urandom_range(9) == 0);
        if (a == 2) d = $urandom_range(3);
        wr(a, d);
      end
    end
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
